// File: rtl/subreg_access_arb.sv
// Round-robin arbiter sharing one register-file access port between NumReq requesters.
// Each transaction runs IDLE (grant) -> ACCESS (strobe) -> RESP (response), one at a time.
module subreg_access_arb #(
  parameter int NumReq = 2,
  parameter int AW     = 8,
  parameter int DW     = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumReq-1:0]    req_i,
  input  logic [NumReq-1:0]    wr_i,
  input  logic [NumReq*AW-1:0] addr_i,
  input  logic [NumReq*DW-1:0] wdata_i,
  output logic [NumReq-1:0]    gnt_o,
  output logic [NumReq-1:0]    rvalid_o,
  output logic [DW-1:0]        rdata_o,
  output logic                 reg_we_o,
  output logic                 reg_re_o,
  output logic [AW-1:0]        reg_addr_o,
  output logic [DW-1:0]        reg_wd_o,
  input  logic [DW-1:0]        reg_rdata_i
);

  localparam int IW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // First requester at or after ptr+1, wrapping; the last winner gets lowest priority.
  function automatic logic [IW-1:0] rr_pick(input logic [NumReq-1:0] req,
                                            input logic [IW-1:0]     ptr);
    logic [IW-1:0] pick;
    logic          found;
    int            cand;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = (int'(ptr) + k) % NumReq;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end
    end
    return pick;
  endfunction

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] sel_q, sel_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [IW-1:0] win;

  assign win = rr_pick(req_i, ptr_q);

  always_comb begin
    // NOTE: every signal gets a default before the case; a missing branch would infer a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    rdata_d  = rdata_q;
    gnt_o    = '0;
    rvalid_o = '0;
    reg_we_o = 1'b0;
    reg_re_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          gnt_o[win] = 1'b1;
          sel_d      = win;
          ptr_d      = win;
          wr_d       = wr_i[win];
          addr_d     = addr_i[win*AW +: AW];
          wd_d       = wdata_i[win*DW +: DW];
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        reg_we_o = wr_q;
        reg_re_o = !wr_q;
        rdata_d  = wr_q ? '0 : reg_rdata_i;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        rvalid_o[sel_q] = 1'b1;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= IW'(NumReq - 1);
      sel_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
    end
  end

  // Address and data stay registered between accesses; only the strobes qualify them.
  assign reg_addr_o = addr_q;
  assign reg_wd_o   = wd_q;
  assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_subreg_access_arb.sv
// Self-checking bench for subreg_access_arb: table-driven single transactions plus
// hand-written contention, withdraw, reset and back-to-back sequences; responses go through a scoreboard.
module tb_subreg_access_arb;

  localparam int NumReq = 2;
  localparam int AW     = 8;
  localparam int DW     = 32;

  logic                 clk_i;
  logic                 rst_ni;
  logic [NumReq-1:0]    req_i;
  logic [NumReq-1:0]    wr_i;
  logic [NumReq*AW-1:0] addr_i;
  logic [NumReq*DW-1:0] wdata_i;
  logic [NumReq-1:0]    gnt_o;
  logic [NumReq-1:0]    rvalid_o;
  logic [DW-1:0]        rdata_o;
  logic                 reg_we_o;
  logic                 reg_re_o;
  logic [AW-1:0]        reg_addr_o;
  logic [DW-1:0]        reg_wd_o;
  logic [DW-1:0]        reg_rdata_i;

  subreg_access_arb #(.NumReq(NumReq), .AW(AW), .DW(DW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .wr_i        (wr_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .reg_we_o    (reg_we_o),
    .reg_re_o    (reg_re_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wd_o    (reg_wd_o),
    .reg_rdata_i (reg_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Register file read mux model
  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    case (a)
      8'h08:   return 32'h1234_5678;
      8'h10:   return 32'hCAFE_F00D;
      8'hFF:   return 32'hFFFF_0000;
      default: return 32'h0BAD_0000 | {24'h0, a};
    endcase
  endfunction

  always_comb reg_rdata_i = rd_model(reg_addr_o);

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          idx;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  task automatic expect_resp(input int idx, input logic [31:0] rdata);
    exp_t e;
    e.idx   = idx;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Response monitor: every rvalid must match the oldest outstanding grant.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if ((gnt_o | rvalid_o) != '0)
        check("onehot_gnt_rvalid", 32'($onehot(gnt_o | rvalid_o)), 32'd1);
      if (rvalid_o != '0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rvalid: got %b expected none at %0t", rvalid_o, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rvalid_port", 32'(rvalid_o), 32'(2'b01 << e.idx));
          check("rdata", rdata_o, e.rdata);
        end
      end
    end
  end

  task automatic drive(input int idx, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    req_i[idx]             = 1'b1;
    wr_i[idx]              = wr;
    addr_i[idx*AW +: AW]   = a;
    wdata_i[idx*DW +: DW]  = wd;
  endtask

  typedef struct {
    int          idx;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  exp_gnt;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 6;
  vec_t vec[NV];

  int we_cnt;
  int we_cyc[2];
  logic [7:0] we_addr[2];
  logic gnt1_seen;

  initial begin
    vec[0] = '{0, 1'b1, 8'h04, 32'hDEAD_BEEF, 2'b01, 32'h0};
    vec[1] = '{1, 1'b0, 8'h08, 32'h0,         2'b10, 32'h1234_5678};
    vec[2] = '{0, 1'b0, 8'h10, 32'h0,         2'b01, 32'hCAFE_F00D};
    vec[3] = '{1, 1'b1, 8'hFF, 32'h0000_0001, 2'b10, 32'h0};
    vec[4] = '{1, 1'b0, 8'hFF, 32'h0,         2'b10, 32'hFFFF_0000};
    vec[5] = '{0, 1'b0, 8'h00, 32'h0,         2'b01, 32'h0BAD_0000};

    rst_ni  = 1'b0;
    req_i   = '0;
    wr_i    = '0;
    addr_i  = '0;
    wdata_i = '0;

    // Reset values
    repeat (2) @(negedge clk_i);
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_rvalid", 32'(rvalid_o), 32'h0);
    check("rst_strobes", {30'h0, reg_we_o, reg_re_o}, 32'h0);
    check("rst_addr", 32'(reg_addr_o), 32'h0);
    check("rst_wd", reg_wd_o, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);

    // Contention right after reset: grants 0,1,0,1 three cycles apart
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    drive(0, 1'b1, 8'h20, 32'h1111_1111);
    drive(1, 1'b1, 8'h21, 32'h2222_2222);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (c % 3 == 0) begin
        check("contend_gnt", 32'(gnt_o), ((c / 3) % 2 == 0) ? 32'h1 : 32'h2);
        expect_resp((c / 3) % 2, 32'h0);
      end else begin
        check("contend_gnt_idle", 32'(gnt_o), 32'h0);
      end
      if (c % 3 == 1)
        check("contend_addr", 32'(reg_addr_o), ((c / 3) % 2 == 0) ? 32'h20 : 32'h21);
      if (c % 3 == 2)
        check("contend_rvalid", 32'(rvalid_o), ((c / 3) % 2 == 0) ? 32'h1 : 32'h2);
    end

    // Table-driven single transactions
    for (int i = 0; i < NV; i++) begin
      @(posedge clk_i); #1;
      req_i = '0;
      drive(vec[i].idx, vec[i].wr, vec[i].addr, vec[i].wdata);
      @(negedge clk_i);
      check("vec_gnt", 32'(gnt_o), 32'(vec[i].exp_gnt));
      expect_resp(vec[i].idx, vec[i].exp_rdata);
      @(posedge clk_i); #1;
      req_i = '0;
      @(negedge clk_i);
      check("vec_we", 32'(reg_we_o), 32'(vec[i].wr));
      check("vec_re", 32'(reg_re_o), 32'(!vec[i].wr));
      check("vec_addr", 32'(reg_addr_o), 32'(vec[i].addr));
      if (vec[i].wr) check("vec_wd", reg_wd_o, vec[i].wdata);
      @(negedge clk_i);
      check("vec_strobes_resp", {30'h0, reg_we_o, reg_re_o}, 32'h0);
    end

    // Early withdraw: req1 pulses for one cycle while req0 is in ACCESS
    @(posedge clk_i); #1;
    drive(0, 1'b1, 8'h50, 32'hA5A5_A5A5);
    @(negedge clk_i);
    check("wd_gnt0", 32'(gnt_o), 32'h1);
    expect_resp(0, 32'h0);
    @(posedge clk_i); #1;
    req_i = '0;
    drive(1, 1'b0, 8'h08, 32'h0);
    @(negedge clk_i);
    check("wd_we", 32'(reg_we_o), 32'h1);
    @(posedge clk_i); #1;
    req_i = '0;
    gnt1_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (gnt_o[1]) gnt1_seen = 1'b1;
    end
    check("wd_no_gnt1", 32'(gnt1_seen), 32'h0);

    // Reset during ACCESS: strobe dropped, transaction lost, pointer restarts
    @(posedge clk_i); #1;
    drive(0, 1'b0, 8'h08, 32'h0);
    @(negedge clk_i);
    check("rstacc_gnt", 32'(gnt_o), 32'h1);
    @(posedge clk_i); #1;
    req_i = '0;
    @(negedge clk_i);
    check("rstacc_re", 32'(reg_re_o), 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    check("rstacc_strobes", {30'h0, reg_we_o, reg_re_o}, 32'h0);
    check("rstacc_addr", 32'(reg_addr_o), 32'h0);
    check("rstacc_rdata", rdata_o, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drive(0, 1'b1, 8'h40, 32'h0000_0055);
    drive(1, 1'b1, 8'h41, 32'h0000_0066);
    @(negedge clk_i);
    check("rstacc_ptr_restart", 32'(gnt_o), 32'h1);
    expect_resp(0, 32'h0);
    @(posedge clk_i); #1;
    req_i = '0;
    @(negedge clk_i);
    check("rstacc_we_addr", {23'h0, reg_we_o, reg_addr_o}, 32'h140);
    @(negedge clk_i);

    // Back-to-back writes from requester 0
    @(posedge clk_i); #1;
    drive(0, 1'b1, 8'h30, 32'h0000_0001);
    we_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk_i);
      check("b2b_gnt", 32'(gnt_o), (c == 0 || c == 3) ? 32'h1 : 32'h0);
      if (c == 0 || c == 3) expect_resp(0, 32'h0);
      if (reg_we_o) begin
        if (we_cnt < 2) begin
          we_cyc[we_cnt]  = c;
          we_addr[we_cnt] = reg_addr_o;
        end
        we_cnt++;
      end
      @(posedge clk_i); #1;
      if (c == 0) drive(0, 1'b1, 8'h31, 32'h0000_0002);
      if (c == 3) req_i = '0;
    end
    check("b2b_we_count", 32'(we_cnt), 32'd2);
    if (we_cnt >= 2) begin
      check("b2b_we_spacing", 32'(we_cyc[1] - we_cyc[0]), 32'd3);
      check("b2b_addr0", 32'(we_addr[0]), 32'h30);
      check("b2b_addr1", 32'(we_addr[1]), 32'h31);
    end

    repeat (3) @(negedge clk_i);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
